// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard controller for a 5-stage RV32 pipeline.
// - Resolves E-stage operand forwarding.
// - Detects load-use stalls and handles branch/jump redirect flushes.
// - Sequences multi-cycle execute ops: holds F/D/E while the op is in E
//   and bubbles M behind it.
// - Keeps a saturating count of stalled fetch cycles.
`timescale 1ns/1ps
module hazard_unit_mc #(
    parameter int AW     = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rs1_e,
    input  logic [AW-1:0]     rs2_e,
    input  logic [AW-1:0]     rd_m,
    input  logic [AW-1:0]     rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic [AW-1:0]     rs1_d,
    input  logic [AW-1:0]     rs2_d,
    input  logic [AW-1:0]     rd_e,
    input  logic              reg_write_e,
    input  logic [1:0]        result_src_e,
    input  logic              mc_start_e,
    input  logic              redirect_e,
    input  logic              stall_cnt_clr,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Down-counter width; MC_LAT-2 is the largest value ever loaded.
    localparam int CW = $clog2(MC_LAT);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(MC_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mc_stall;
    logic             lw_stall;

    // Forwarding select for one operand: the M-stage result is newer than
    // the W-stage result, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic [AW-1:0] rdm,
        input logic          wem,
        input logic [AW-1:0] rdw,
        input logic          wew
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0 && rs == rdm && wem) begin
            sel = 2'b10;
        end else if (rs != '0 && rs == rdw && wew) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Operand forwarding selects, zero-cycle combinational.
    always_comb begin
        forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
        forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

    // Load-use hazard: a load in E feeds a source register read in D.
    always_comb begin
        lw_stall = (result_src_e == 2'b01) && reg_write_e && (rd_e != '0) &&
                   ((rs1_d == rd_e) || (rs2_d == rd_e));
    end

    // Multi-cycle sequencer next state. The IDLE cycle that sees the op is
    // its first E cycle; BUSY with cnt==0 is its last, so that cycle stalls
    // nothing and the op leaves E at the following edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mc_start_e) begin
                    mc_stall = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    mc_stall = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset drops out of BUSY immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall/flush resolution: the multi-cycle hold dominates, then a
    // redirect (which must never stall F so the new PC is taken), then the
    // load-use bubble.
    always_comb begin
        stall_f = mc_stall | (lw_stall & ~redirect_e);
        stall_d = mc_stall | (lw_stall & ~redirect_e);
        stall_e = mc_stall;
        flush_m = mc_stall;
        flush_d = redirect_e & ~mc_stall;
        flush_e = (redirect_e | lw_stall) & ~mc_stall;
        mc_busy = (state_q == S_BUSY);
    end

    // Stall counter next value: clear wins, otherwise count and saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall_f && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model that tracks how far a
// multi-cycle op has progressed through E.
`timescale 1ns/1ps
module tb_hazard_unit_mc;

    localparam int AW     = 5;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    rs1_e, rs2_e, rd_m, rd_w, rs1_d, rs2_d, rd_e;
    logic             reg_write_m, reg_write_w, reg_write_e;
    logic [1:0]       result_src_e;
    logic             mc_start_e, redirect_e, stall_cnt_clr;
    logic [1:0]       forward_a_e, forward_b_e;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: pos = 0 when no op occupies E beyond its first cycle,
    // otherwise the index (1..MC_LAT-1) of the current E cycle of the op.
    int pos  = 0;
    int cntm = 0;
    int pos_n, cntm_n;

    always #5 clk = ~clk;

    hazard_unit_mc #(.AW(AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e),
        .mc_start_e(mc_start_e), .redirect_e(redirect_e),
        .stall_cnt_clr(stall_cnt_clr),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .mc_busy(mc_busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int ref_fwd(input int rs, input int rdm, input bit wm,
                                   input int rdw, input bit ww);
        if (rs != 0 && rs == rdm && wm) return 2;
        if (rs != 0 && rs == rdw && ww) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        rs1_e = 0; rs2_e = 0; rd_m = 0; rd_w = 0; rs1_d = 0; rs2_d = 0; rd_e = 0;
        reg_write_m = 0; reg_write_w = 0; reg_write_e = 0; result_src_e = 0;
        mc_start_e = 0; redirect_e = 0; stall_cnt_clr = 0;
    endtask

    // Compare every output with the model, then compute the model's next state.
    task automatic check_all();
        bit mcs, lw, sf;
        mcs = (pos == 0) ? mc_start_e : (pos < MC_LAT - 1);
        lw  = (result_src_e == 2'b01) && reg_write_e && (rd_e != 0) &&
              ((rs1_d == rd_e) || (rs2_d == rd_e));
        sf  = mcs || (lw && !redirect_e);
        chk("fwd_a",     32'(forward_a_e), 32'(ref_fwd(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w)));
        chk("fwd_b",     32'(forward_b_e), 32'(ref_fwd(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w)));
        chk("stall_f",   32'(stall_f), 32'(sf));
        chk("stall_d",   32'(stall_d), 32'(sf));
        chk("stall_e",   32'(stall_e), 32'(mcs));
        chk("flush_m",   32'(flush_m), 32'(mcs));
        chk("flush_d",   32'(flush_d), 32'(redirect_e && !mcs));
        chk("flush_e",   32'(flush_e), 32'((redirect_e || lw) && !mcs));
        chk("mc_busy",   32'(mc_busy), 32'(pos != 0));
        chk("stall_cnt", 32'(stall_cnt), 32'(cntm));
        if (pos == 0)               pos_n = mc_start_e ? 1 : 0;
        else if (pos == MC_LAT - 1) pos_n = 0;
        else                        pos_n = pos + 1;
        if (stall_cnt_clr)          cntm_n = 0;
        else if (sf && cntm < CMAX) cntm_n = cntm + 1;
        else                        cntm_n = cntm;
    endtask

    // One clock: check at the falling edge, advance the model after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        pos  = pos_n;
        cntm = cntm_n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_cnt",  32'(stall_cnt), 32'd0);
        chk("rst_stall_e", 32'(stall_e), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Forwarding
        rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
        #1 chk("fwd_m_prio", 32'(forward_a_e), 32'd2);
        cycle();
        reg_write_m = 0;
        #1 chk("fwd_w", 32'(forward_a_e), 32'd1);
        cycle();
        rs2_e = 0; rd_m = 0; reg_write_m = 1;
        #1 chk("fwd_x0", 32'(forward_b_e), 32'd0);
        cycle();

        // Load-use
        clear_inputs();
        result_src_e = 2'b01; reg_write_e = 1; rd_e = 7; rs2_d = 7;
        #1;
        chk("lu_stall_f", 32'(stall_f), 32'd1);
        chk("lu_flush_e", 32'(flush_e), 32'd1);
        chk("lu_flush_d", 32'(flush_d), 32'd0);
        cycle();
        chk("lu_cnt_inc", 32'(stall_cnt), 32'd1);
        rd_e = 0; rs2_d = 0;
        #1 chk("lu_x0", 32'(stall_f), 32'd0);
        cycle();

        // Redirect with load-use
        rd_e = 7; rs2_d = 7; redirect_e = 1;
        #1;
        chk("rdlu_flush_d", 32'(flush_d), 32'd1);
        chk("rdlu_flush_e", 32'(flush_e), 32'd1);
        chk("rdlu_stall_f", 32'(stall_f), 32'd0);
        cycle();

        // Multi-cycle op, start held cycles 0..3
        clear_inputs();
        stall_cnt_clr = 1;
        cycle();
        stall_cnt_clr = 0;
        mc_start_e = 1;
        for (int c = 0; c < MC_LAT; c++) begin
            #1;
            chk("mc_stall_e", 32'(stall_e), 32'(c < MC_LAT - 1));
            chk("mc_flush_m", 32'(flush_m), 32'(c < MC_LAT - 1));
            chk("mc_busy_seq", 32'(mc_busy), 32'(c >= 1));
            cycle();
        end
        mc_start_e = 0;
        #1 chk("mc_cnt", 32'(stall_cnt), 32'(MC_LAT - 1));
        cycle();

        // Redirect during BUSY
        mc_start_e = 1;
        cycle();
        redirect_e = 1;
        #1;
        chk("rdbusy_flush_d", 32'(flush_d), 32'd0);
        chk("rdbusy_flush_e", 32'(flush_e), 32'd0);
        chk("rdbusy_stall_e", 32'(stall_e), 32'd1);
        cycle();
        clear_inputs();
        repeat (MC_LAT) cycle();

        // Asynchronous reset mid-BUSY
        mc_start_e = 1;
        cycle();
        mc_start_e = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(mc_busy), 32'd0);
        chk("arst_stall_e", 32'(stall_e), 32'd0);
        pos = 0; cntm = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mc_start_e = 1;
        for (int c = 0; c < MC_LAT; c++) begin
            #1;
            chk("post_rst_stall_e", 32'(stall_e), 32'(c < MC_LAT - 1));
            chk("post_rst_busy", 32'(mc_busy), 32'(c >= 1));
            cycle();
        end
        clear_inputs();
        cycle();

        // Saturation and clear-over-increment
        result_src_e = 2'b01; reg_write_e = 1; rd_e = 7; rs1_d = 7;
        repeat (20) cycle();
        chk("sat", 32'(stall_cnt), 32'(CMAX));
        stall_cnt_clr = 1;
        cycle();
        chk("clr_wins", 32'(stall_cnt), 32'd0);
        clear_inputs();
        cycle();

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_m  = 5'($urandom_range(0, 3)); rd_w  = 5'($urandom_range(0, 3));
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            reg_write_e = 1'($urandom); result_src_e = 2'($urandom);
            mc_start_e    = ($urandom_range(0, 7) == 0);
            redirect_e    = ($urandom_range(0, 5) == 0);
            stall_cnt_clr = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
